wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter.
- Shares one slave, typically the SPI SRAM controller, between the SPI-to-Wishbone bridge (master 0) and the Levenshtein engine master port (master 1).
- Grants are round-robin, registered, and held for the whole cycle of the granted master (cyc high).
- An optional watchdog terminates stalled transfers with err.

Parameters:
- ADDR_WIDTH, 23: address width on all ports.
- DATA_WIDTH, 8: data width on all ports.
- TIMEOUT_CYCLES, 255: watchdog limit in clk_i cycles, 1..65535; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- wbm0_cyc_i, wbm0_stb_i, wbm0_we_i  in  1 each  master 0 cycle, strobe, write enable.
- wbm0_adr_i  in  ADDR_WIDTH  master 0 address.
- wbm0_dat_i  in  DATA_WIDTH  master 0 write data.
- wbm0_ack_o, wbm0_err_o, wbm0_rty_o  out  1 each  master 0 termination.
- wbm0_dat_o  out  DATA_WIDTH  master 0 read data.
- wbm1_*  same set as wbm0_*  master 1.
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  slave cycle, strobe, write enable.
- wbs_adr_o  out  ADDR_WIDTH  slave address.
- wbs_dat_o  out  DATA_WIDTH  slave write data.
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  slave termination.
- wbs_dat_i  in  DATA_WIDTH  slave read data.
- grant_o  out  2  one-hot current grant, 00 when idle; debug/status.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, last=1 (so master 0 wins the first tie), timeout counter=0.
  - Every output is 0.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - Only wbm0_cyc_i high -> GNT0. Only wbm1_cyc_i high -> GNT1.
  - Both high -> grant the master that is not `last`.
  - Neither high -> stay in IDLE.
  - Grant latency is 1 cycle: cyc seen at edge N, wbs_cyc_o high after edge N.
- GNTx:
  - wbs_cyc/stb/we/adr/dat outputs are combinational copies of master x's signals.
  - Slave ack/err/rty and read data are routed only to master x.
  - When wbm x_cyc_i is low at the clock edge: go to IDLE and set last=x.
  - A new grant is therefore always separated from the previous one by at least 1 idle cycle.
- Non-granted master:
  - ack/err/rty/dat_o held at 0; its stb is ignored and it waits.
- Slave data bus:
  - wbs_dat_o, wbs_adr_o and wbs_we_o are 0 in IDLE.
- Cycle drop mid-transfer:
  - If the granted master drops cyc while stb is high and no ack has arrived, wbs_cyc_o/wbs_stb_o drop combinationally in the same cycle.
  - A late slave ack after the drop is discarded.
- Fairness:
  - With both masters requesting continuously, grants alternate 0,1,0,1.
  - No master waits longer than one full cycle of the other master.
- Locked cycles:
  - A master keeping cyc high across several stb transfers keeps the grant throughout (RMW and burst safe).
- Reset mid-transfer:
  - All outputs drop immediately and the arbiter returns to IDLE.
  - The in-flight transfer is abandoned; masters must restart it.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs while the arbiter is in GNTx, wbs_stb_o=1, and ack/err/rty are all 0.
  - The counter clears on any termination or when stb is low.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter:
    - asserts wbmx_err_o for exactly 1 cycle, with wbs_stb_o forced to 0 in that cycle;
    - clears the counter;
    - keeps the grant.
  - Slave responses in the err cycle are discarded.
- When undefined:
  - No counter is built; a stalled slave stalls the granted master indefinitely.

Test Plan:
- Single master: m0 writes adr 0x000010, dat 0xA5, slave acks after 3 cycles -> wbs_cyc_o rises 1 cycle after wbm0_cyc_i, wbm0_ack_o pulses once, grant_o=01, wbm1_ack_o stays 0.
- Simultaneous request from reset: both cyc rise together -> m0 granted first (grant_o=01); after m0 drops cyc, 1 idle cycle, then grant_o=10.
- Fairness: both masters issue 4 single-read cycles back to back -> grant order 0,1,0,1,0,1,0,1; read data 0x3C is routed only to the granted master.
- Locked cycle: m1 holds cyc across 3 stb transfers while m0 is requesting -> grant_o stays 10 for all 3 acks; m0 is granted only after m1 drops cyc.
- Abort and reset: m0 drops cyc before ack -> wbs_cyc_o is 0 in the same cycle. Separately, rst_i pulses mid-transfer -> all outputs are 0 asynchronously and state is IDLE.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks -> wbm0_err_o pulses once after 8 stalled stb cycles, with wbs_stb_o=0 in that cycle. With the macro undefined, there is no err after 100 cycles.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
`timescale 1ns/1ps
// Two-master round-robin Wishbone B4 classic arbiter; optional stall watchdog via WB_ARB_TIMEOUT_EN.
// Grant registered (1 cycle after cyc), held while granted cyc is high; losers wait with all responses at 0.
module wb_rr_arbiter #(
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wbm0_cyc_i,
    input  logic                  wbm0_stb_i,
    input  logic                  wbm0_we_i,
    input  logic [ADDR_WIDTH-1:0] wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0] wbm0_dat_i,
    output logic                  wbm0_ack_o,
    output logic                  wbm0_err_o,
    output logic                  wbm0_rty_o,
    output logic [DATA_WIDTH-1:0] wbm0_dat_o,
    input  logic                  wbm1_cyc_i,
    input  logic                  wbm1_stb_i,
    input  logic                  wbm1_we_i,
    input  logic [ADDR_WIDTH-1:0] wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0] wbm1_dat_i,
    output logic                  wbm1_ack_o,
    output logic                  wbm1_err_o,
    output logic                  wbm1_rty_o,
    output logic [DATA_WIDTH-1:0] wbm1_dat_o,
    output logic                  wbs_cyc_o,
    output logic                  wbs_stb_o,
    output logic                  wbs_we_o,
    output logic [ADDR_WIDTH-1:0] wbs_adr_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    input  logic                  wbs_ack_i,
    input  logic                  wbs_err_i,
    input  logic                  wbs_rty_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;
    logic   w_tmo_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == GNT0 && !wbm0_cyc_i) r_last <= 1'b0;
            if (r_state == GNT1 && !wbm1_cyc_i) r_last <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (wbm0_cyc_i && wbm1_cyc_i) w_next = r_last ? GNT0 : GNT1;
                else if (wbm0_cyc_i)          w_next = GNT0;
                else if (wbm1_cyc_i)          w_next = GNT1;
            end
            GNT0:    if (!wbm0_cyc_i) w_next = IDLE;
            GNT1:    if (!wbm1_cyc_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_tmo_err;
    logic        w_req_stb;
    logic        w_stall;

    assign w_req_stb = (r_state == GNT0 && wbm0_cyc_i && wbm0_stb_i) ||
                       (r_state == GNT1 && wbm1_cyc_i && wbm1_stb_i);
    // The err cycle itself is not a stall: stb is forced low there.
    assign w_stall   = w_req_stb && !r_tmo_err && !(wbs_ack_i || wbs_err_i || wbs_rty_i);
    assign w_tmo_err = r_tmo_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= 1'b0;
            if (!w_stall) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt == TMO_LAST) begin
                r_tmo_cnt <= '0;
                r_tmo_err <= 1'b1;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_tmo_err    = 1'b0;
`endif

    // Responses are gated by the granted cyc so a late ack after an abort is dropped.
    always_comb begin
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_we_o   = 1'b0;
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm0_rty_o = 1'b0;
        wbm0_dat_o = '0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        wbm1_rty_o = 1'b0;
        wbm1_dat_o = '0;
        grant_o    = 2'b00;
        case (r_state)
            GNT0: begin
                grant_o    = 2'b01;
                wbs_cyc_o  = wbm0_cyc_i;
                wbs_stb_o  = wbm0_cyc_i && wbm0_stb_i && !w_tmo_err;
                wbs_we_o   = wbm0_we_i;
                wbs_adr_o  = wbm0_adr_i;
                wbs_dat_o  = wbm0_dat_i;
                wbm0_ack_o = wbm0_cyc_i && wbs_ack_i && !w_tmo_err;
                wbm0_err_o = (wbm0_cyc_i && wbs_err_i && !w_tmo_err) || w_tmo_err;
                wbm0_rty_o = wbm0_cyc_i && wbs_rty_i && !w_tmo_err;
                wbm0_dat_o = wbs_dat_i;
            end
            GNT1: begin
                grant_o    = 2'b10;
                wbs_cyc_o  = wbm1_cyc_i;
                wbs_stb_o  = wbm1_cyc_i && wbm1_stb_i && !w_tmo_err;
                wbs_we_o   = wbm1_we_i;
                wbs_adr_o  = wbm1_adr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbm1_ack_o = wbm1_cyc_i && wbs_ack_i && !w_tmo_err;
                wbm1_err_o = (wbm1_cyc_i && wbs_err_i && !w_tmo_err) || w_tmo_err;
                wbm1_rty_o = wbm1_cyc_i && wbs_rty_i && !w_tmo_err;
                wbm1_dat_o = wbs_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
`timescale 1ns/1ps
// Directed vector table plus hand sequences for fairness, locked cycles, abort, reset and watchdog.
module tb_wb_rr_arbiter;
    localparam int AW = 23;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [AW-1:0] m0_adr = 23'h000010, m1_adr = 23'h000020;
    logic [DW-1:0] m0_dat = 8'hA5, m1_dat = 8'h5A;
    logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic [DW-1:0] m0_dato, m1_dato;
    logic s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dato;
    logic s_ack = 0, s_err = 0, s_rty = 0;
    logic [DW-1:0] s_dat = '0;
    logic [1:0] grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .wbm0_cyc_i(m0_cyc), .wbm0_stb_i(m0_stb), .wbm0_we_i(m0_we),
        .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat),
        .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err), .wbm0_rty_o(m0_rty), .wbm0_dat_o(m0_dato),
        .wbm1_cyc_i(m1_cyc), .wbm1_stb_i(m1_stb), .wbm1_we_i(m1_we),
        .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat),
        .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err), .wbm1_rty_o(m1_rty), .wbm1_dat_o(m1_dato),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dato),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty), .wbs_dat_i(s_dat),
        .grant_o(grant)
    );

    typedef struct {
        logic rst, c0, s0, c1, s1, ack;
        logic [7:0] sdat;
        logic [1:0] gnt;
        logic cyc, stb, a0, a1;
        logic [7:0] d0, d1, sdo;
        logic [22:0] adr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, c0, s0, c1, s1, ack, input logic [7:0] sdat,
                                input logic [1:0] gnt, input logic cyc, stb, a0, a1,
                                input logic [7:0] d0, d1, sdo, input logic [22:0] adr);
        vec_t v;
        v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.sdat = sdat;
        v.gnt = gnt; v.cyc = cyc; v.stb = stb; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.sdo = sdo; v.adr = adr;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_dat = '0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        vec_t vt[17];
        int order[$];
        int n0, n1, err_at, errs;
        logic drop0, drop1, stb_in_err, stb_before;

        // rst c0 s0 c1 s1 ack sdat | gnt cyc stb a0 a1 d0 d1 sdo adr
        vt[0]  = mk(0,0,0,0,0,0,8'h00, 2'b00,0,0,0,0,8'h00,8'h00,8'h00,23'h00);
        vt[1]  = mk(0,1,1,0,0,0,8'h00, 2'b00,0,0,0,0,8'h00,8'h00,8'h00,23'h00);
        vt[2]  = mk(0,1,1,0,0,0,8'h00, 2'b01,1,1,0,0,8'h00,8'h00,8'hA5,23'h10);
        vt[3]  = mk(0,1,1,0,0,0,8'h00, 2'b01,1,1,0,0,8'h00,8'h00,8'hA5,23'h10);
        vt[4]  = mk(0,1,1,0,0,1,8'h3C, 2'b01,1,1,1,0,8'h3C,8'h00,8'hA5,23'h10);
        vt[5]  = mk(0,0,0,0,0,0,8'h00, 2'b01,0,0,0,0,8'h00,8'h00,8'hA5,23'h10);
        vt[6]  = mk(0,0,0,0,0,0,8'h00, 2'b00,0,0,0,0,8'h00,8'h00,8'h00,23'h00);
        vt[7]  = mk(1,0,0,0,0,0,8'h00, 2'b00,0,0,0,0,8'h00,8'h00,8'h00,23'h00);
        vt[8]  = mk(0,1,1,1,1,0,8'h00, 2'b00,0,0,0,0,8'h00,8'h00,8'h00,23'h00);
        vt[9]  = mk(0,1,1,1,1,0,8'h00, 2'b01,1,1,0,0,8'h00,8'h00,8'hA5,23'h10);
        vt[10] = mk(0,1,1,1,1,1,8'h3C, 2'b01,1,1,1,0,8'h3C,8'h00,8'hA5,23'h10);
        vt[11] = mk(0,0,0,1,1,0,8'h00, 2'b01,0,0,0,0,8'h00,8'h00,8'hA5,23'h10);
        vt[12] = mk(0,0,0,1,1,0,8'h00, 2'b00,0,0,0,0,8'h00,8'h00,8'h00,23'h00);
        vt[13] = mk(0,0,0,1,1,0,8'h00, 2'b10,1,1,0,0,8'h00,8'h00,8'h5A,23'h20);
        vt[14] = mk(0,0,0,1,1,1,8'h3C, 2'b10,1,1,0,1,8'h00,8'h3C,8'h5A,23'h20);
        vt[15] = mk(0,0,0,0,0,0,8'h00, 2'b10,0,0,0,0,8'h00,8'h00,8'h5A,23'h20);
        vt[16] = mk(0,0,0,0,0,0,8'h00, 2'b00,0,0,0,0,8'h00,8'h00,8'h00,23'h00);

        m0_we = 1; m1_we = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            rst = vt[i].rst; m0_cyc = vt[i].c0; m0_stb = vt[i].s0;
            m1_cyc = vt[i].c1; m1_stb = vt[i].s1; s_ack = vt[i].ack; s_dat = vt[i].sdat;
            @(negedge clk);
            chk($sformatf("v%0d_grant", i), grant, vt[i].gnt);
            chk($sformatf("v%0d_scyc", i), s_cyc, vt[i].cyc);
            chk($sformatf("v%0d_sstb", i), s_stb, vt[i].stb);
            chk($sformatf("v%0d_ack0", i), m0_ack, vt[i].a0);
            chk($sformatf("v%0d_ack1", i), m1_ack, vt[i].a1);
            chk($sformatf("v%0d_dat0", i), m0_dato, vt[i].d0);
            chk($sformatf("v%0d_dat1", i), m1_dato, vt[i].d1);
            chk($sformatf("v%0d_sdat", i), s_dato, vt[i].sdo);
            chk($sformatf("v%0d_sadr", i), s_adr, vt[i].adr);
        end

        // fairness: both masters do 4 single reads, slave acks as soon as stb is seen
        do_reset();
        m0_we = 0; n0 = 0; n1 = 0; drop0 = 0; drop1 = 0;
        for (int c = 0; c < 200 && order.size() < 8; c++) begin
            @(posedge clk); #1;
            m0_cyc = (n0 < 4) && !drop0; m0_stb = m0_cyc;
            m1_cyc = (n1 < 4) && !drop1; m1_stb = m1_cyc;
            drop0 = 0; drop1 = 0;
            #1;
            s_ack = s_stb; s_dat = 8'h3C;
            @(negedge clk);
            if (m0_ack) begin
                order.push_back(0); n0++; drop0 = 1;
                chk("fair_dat0", m0_dato, 8'h3C);
                chk("fair_quiet1", {m1_ack, m1_dato}, 9'h000);
            end
            if (m1_ack) begin
                order.push_back(1); n1++; drop1 = 1;
                chk("fair_dat1", m1_dato, 8'h3C);
                chk("fair_quiet0", {m0_ack, m0_dato}, 9'h000);
            end
        end
        chk("fair_count", order.size(), 8);
        for (int i = 0; i < order.size(); i++) chk($sformatf("fair_order%0d", i), order[i], i % 2);

        // locked cycle: m1 keeps cyc across 3 transfers while m0 waits
        do_reset();
        @(posedge clk); #1; m1_cyc = 1; m1_stb = 0;
        @(negedge clk); chk("lock_idle", grant, 2'b00);
        @(posedge clk); #1; m0_cyc = 1; m0_stb = 1;
        @(negedge clk); chk("lock_gnt", grant, 2'b10);
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1; m1_stb = 1; #1; s_ack = s_stb;
            @(negedge clk);
            chk($sformatf("lock%0d_grant", t), grant, 2'b10);
            chk($sformatf("lock%0d_ack1", t), m1_ack, 1'b1);
            chk($sformatf("lock%0d_ack0", t), m0_ack, 1'b0);
            @(posedge clk); #1; m1_stb = 0; s_ack = 0;
            @(negedge clk); chk($sformatf("lock%0d_gap", t), grant, 2'b10);
        end
        @(posedge clk); #1; m1_cyc = 0;
        @(negedge clk); chk("lock_drop_grant", grant, 2'b10); chk("lock_drop_cyc", s_cyc, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("lock_gap_idle", grant, 2'b00);
        @(posedge clk); #1;
        @(negedge clk); chk("lock_m0_grant", grant, 2'b01); chk("lock_m0_stb", s_stb, 1'b1);

        // abort: m0 drops cyc before any ack, then a late ack arrives
        @(posedge clk); #1; m0_cyc = 0; m0_stb = 0; s_ack = 1;
        @(negedge clk);
        chk("abort_cyc", s_cyc, 1'b0); chk("abort_stb", s_stb, 1'b0); chk("abort_ack", m0_ack, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("abort_idle", grant, 2'b00); chk("abort_late_ack", m0_ack, 1'b0);
        s_ack = 0;

        // asynchronous reset in the middle of a transfer
        do_reset();
        s_dat = 8'h3C;
        @(posedge clk); #1; m0_cyc = 1; m0_stb = 1;
        @(posedge clk); #1;
        @(negedge clk); chk("rst_pre_cyc", s_cyc, 1'b1);
        #1 rst = 1;
        #1;
        chk("rst_async_cyc", s_cyc, 1'b0); chk("rst_async_stb", s_stb, 1'b0);
        chk("rst_async_grant", grant, 2'b00); chk("rst_async_adr", s_adr, 23'h0);
        chk("rst_async_dat0", m0_dato, 8'h00);
        @(posedge clk); #1; rst = 0;
        @(negedge clk); chk("rst_idle", grant, 2'b00);
        @(posedge clk); #1;
        @(negedge clk); chk("rst_regrant", grant, 2'b01);

        // stalled slave: watchdog err (TIMEOUT_CYCLES=8) or indefinite stall
        do_reset();
        @(posedge clk); #1; m0_cyc = 1; m0_stb = 1;
        err_at = -1; errs = 0; stb_in_err = 1'b1; stb_before = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (errs > 0) begin m0_cyc = 0; m0_stb = 0; end
            @(negedge clk);
            if (c == 8) stb_before = s_stb;
            if (m0_err) begin
                errs++;
                if (err_at < 0) begin err_at = c; stb_in_err = s_stb; end
            end
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("tmo_err_cycle", err_at, 9);
        chk("tmo_err_once", errs, 1);
        chk("tmo_stb_in_err", stb_in_err, 1'b0);
        chk("tmo_stb_before", stb_before, 1'b1);
`else
        chk("stall_no_err", errs, 0);
        chk("stall_stb_held", s_stb, 1'b1);
        chk("stall_grant_held", grant, 2'b01);
        chk("stall_stb_c8", stb_before, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
